// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; issues data-bus requests, waits for ack, and forms the MEM/WB writeback.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   wR_in..funct3_in         EX/MEM slot (held stable by upstream while stall_out=1)
//   dbus_*                   word-aligned data bus; request held stable until dbus_ack
//   wR_out..misalign_out     registered MEM/WB slot
//   stall_out                holds upstream while a bus access is outstanding
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wR_in,
    input  logic [31:0] rD2_in,
    input  logic [31:0] aluc_in,
    input  logic [31:0] wD_in,
    input  logic [31:0] pc_in,
    input  logic        have_inst_in,
    input  logic [1:0]  rf_wsel_in,
    input  logic        rf_we_in,
    input  logic        ram_we_in,
    input  logic [2:0]  funct3_in,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [4:0]  wR_out,
    output logic [31:0] wD_out,
    output logic [31:0] pc_out,
    output logic        have_inst_out,
    output logic        rf_we_out,
    output logic        misalign_out,
    output logic        stall_out
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [4:0]  wR_q, wR_d;
    logic [31:0] wD_q, wD_d, pc_q, pc_d;
    logic        have_q, have_d, rf_we_q, rf_we_d, mis_q, mis_d;
    logic [1:0]  off, size;
    logic        memop, misaligned, aligned_mem, stall;
    logic [31:0] lane_shift, ld_ext, wb, st_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [3:0]  st_strb;
    always_comb begin
        off         = aluc_in[1:0];
        size        = funct3_in[1:0];
        memop       = have_inst_in && (ram_we_in || rf_wsel_in == 2'b01);
        misaligned  = (size == 2'b01 && off[0]) || (size[1] && off != 2'b00);
        aligned_mem = memop && !misaligned;
        // byte lane picked by the low address bits; halfword by addr[1]
        lane_shift  = dbus_rdata >> {off, 3'b000};
        ld_b        = lane_shift[7:0];
        ld_h        = off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        ld_ext      = size == 2'b00 ? {{24{!funct3_in[2] && ld_b[7]}}, ld_b} :
                      size == 2'b01 ? {{16{!funct3_in[2] && ld_h[15]}}, ld_h} : dbus_rdata;
        wb          = rf_wsel_in == 2'b00 ? aluc_in : rf_wsel_in == 2'b01 ? ld_ext : wD_in;
        st_data     = size == 2'b00 ? {4{rD2_in[7:0]}} : size == 2'b01 ? {2{rD2_in[15:0]}} : rD2_in;
        st_strb     = !ram_we_in ? 4'b0000 : size == 2'b00 ? 4'b0001 << off :
                      size == 2'b01 ? 4'b0011 << off : 4'b1111;
        stall       = state_q == IDLE ? aligned_mem : !dbus_ack;
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        if (state_q == IDLE && aligned_mem) begin
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = ram_we_in;
            addr_d  = {aluc_in[31:2], 2'b00};
            wdata_d = st_data;
            wstrb_d = st_strb;
        end else if (state_q == WAIT && dbus_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            wstrb_d = 4'b0000;
        end
        // a stalled cycle still advances MEM/WB, but only with a bubble
        wR_d    = wR_in;
        wD_d    = wb;
        pc_d    = pc_in;
        have_d  = stall ? 1'b0 : have_inst_in;
        rf_we_d = stall ? 1'b0 : have_inst_in && rf_we_in && !ram_we_in && !(memop && misaligned);
        mis_d   = stall ? 1'b0 : memop && misaligned;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wR_q    <= '0;
            wD_q    <= '0;
            pc_q    <= '0;
            have_q  <= 1'b0;
            rf_we_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wR_q    <= wR_d;
            wD_q    <= wD_d;
            pc_q    <= pc_d;
            have_q  <= have_d;
            rf_we_q <= rf_we_d;
            mis_q   <= mis_d;
        end
    end
    assign dbus_req      = req_q;
    assign dbus_we       = we_q;
    assign dbus_addr     = addr_q;
    assign dbus_wdata    = wdata_q;
    assign dbus_wstrb    = wstrb_q;
    assign wR_out        = wR_q;
    assign wD_out        = wD_q;
    assign pc_out        = pc_q;
    assign have_inst_out = have_q;
    assign rf_we_out     = rf_we_q;
    assign misalign_out  = mis_q;
    // reset must silence the stall even though the slot inputs may look like a memory op
    assign stall_out     = !rst && stall;
endmodule
